// File: rtl/qpu_exu_timed_event_queue.sv
// Timestamped event queue for the QPU execution unit.
// Entries wait in a circular buffer until the timeline reaches their
// timestamp, then issue to NCH channels gated by measurement feedback.
// Stale entries are dropped and flagged. An entry pushed into an empty
// queue at exactly the current time bypasses storage.
module qpu_exu_timed_event_queue #(
  parameter int TW  = 16,
  parameter int DP  = 8,
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = $clog2(DP + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push_vld,
  output logic              o_push_rdy,
  input  logic [TW-1:0]     i_push_time,
  input  logic [NCH-1:0]    i_push_mask,
  input  logic [NCH*DW-1:0] i_push_data,
  input  logic [NCH*2-1:0]  i_push_cond,
  input  logic              i_run,
  input  logic [TW-1:0]     i_now,
  output logic              o_timer_ena,
  input  logic [NCH-1:0]    i_meas_zero,
  input  logic [NCH-1:0]    i_meas_one,
  input  logic [NCH-1:0]    i_meas_equ,
  output logic [NCH-1:0]    o_ev_vld,
  output logic [NCH*DW-1:0] o_ev_data,
  input  logic              i_flush,
  input  logic              i_clr_err,
  output logic [CW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_late_err
);

  localparam int AW = (DP > 1) ? $clog2(DP) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DP);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [TW-1:0]     mem_time [DP];
  logic [NCH-1:0]    mem_mask [DP];
  logic [NCH*DW-1:0] mem_data [DP];
  logic [NCH*2-1:0]  mem_cond [DP];

  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic          late_err;

  logic          push, due, late, pop, bypass, store, issue_go;
  logic [TW-1:0] head_time;
  logic [NCH-1:0]    sel_mask, iss_vld;
  logic [NCH*DW-1:0] sel_data, iss_data;
  logic [NCH*2-1:0]  sel_cond;

  // Feedback condition: 00 always, 01 meas one, 10 meas zero, 11 meas equal
  function automatic logic cond_pass(input logic [1:0] c, input logic one,
                                     input logic zero, input logic equ);
    case (c)
      2'b00:   return 1'b1;
      2'b01:   return one;
      2'b10:   return zero;
      default: return equ;
    endcase
  endfunction

  assign o_empty    = (count == '0);
  assign o_full     = (count == FULL_CNT);
  assign o_push_rdy = ~o_full;
  assign o_count    = count;
  assign o_late_err = late_err;

  assign head_time = mem_time[rptr];
  assign push      = i_push_vld & o_push_rdy;
  assign due       = i_run & ~o_empty & (head_time == i_now);
  assign late      = i_run & ~o_empty & (head_time < i_now);
  assign pop       = due | late;
  assign bypass    = o_empty & push & i_run & (i_push_time == i_now);
  assign store     = push & ~bypass & ~i_flush;
  assign issue_go  = (due | bypass) & ~i_flush;

  // Hold the timeline when the queue is (or is about to become) empty
  assign o_timer_ena = i_run & ~(o_empty & ~i_push_vld)
                     & ~(pop & (count == ONE_CNT) & ~push);

  // Select the issuing bundle and apply per-channel feedback gating
  always_comb begin
    sel_mask = '0;
    sel_data = '0;
    sel_cond = '0;
    iss_vld  = '0;
    iss_data = '0;
    if (issue_go) begin
      sel_mask = due ? mem_mask[rptr] : i_push_mask;
      sel_data = due ? mem_data[rptr] : i_push_data;
      sel_cond = due ? mem_cond[rptr] : i_push_cond;
    end
    for (int c = 0; c < NCH; c++) begin
      if (sel_mask[c] && cond_pass(sel_cond[c*2 +: 2], i_meas_one[c],
                                   i_meas_zero[c], i_meas_equ[c])) begin
        iss_vld[c]             = 1'b1;
        iss_data[c*DW +: DW]   = sel_data[c*DW +: DW];
      end
    end
  end

  // Entry storage; contents need no reset since occupancy guards reads
  always_ff @(posedge clk) begin
    if (store) begin
      mem_time[wptr] <= i_push_time;
      mem_mask[wptr] <= i_push_mask;
      mem_data[wptr] <= i_push_data;
      mem_cond[wptr] <= i_push_cond;
    end
  end

  // Pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (i_flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (store) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      count <= count + CW'(store) - CW'(pop);
    end
  end

  // Registered issue outputs, one-cycle strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ev_vld  <= '0;
      o_ev_data <= '0;
    end else begin
      o_ev_vld  <= iss_vld;
      o_ev_data <= iss_data;
    end
  end

  // Sticky late flag; a new late event beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      late_err <= 1'b0;
    end else if (late && !i_flush) begin
      late_err <= 1'b1;
    end else if (i_clr_err) begin
      late_err <= 1'b0;
    end
  end

endmodule
